hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline hazard unit for the 5-stage RISC-V core. Keeps the existing functions: E-stage and D-stage forwarding, load-use stall, branch-operand stall and decode flush. Adds a scoreboard for a long-latency unit (mul/div) with up to LU_DEPTH in-order outstanding ops, a per-op latency watchdog and a saturating stall-cycle counter. Sits beside the datapath and is driven by stage register fields.

Parameters:
NUM_REGS, 32, architectural registers; x0 is never busy and never forwarded
REG_AW, 5, register address width, equal to clog2(NUM_REGS)
LU_DEPTH, 4, max outstanding long-unit ops (power of 2, >=2)
MAX_LAT, 34, cycles after which an outstanding head op times out
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_rs1_D, i_rs2_D, i_rd_D  in  REG_AW each  decode source and destination registers
i_rf_wr_en_D, i_branch_D, i_branch_taken_D, i_lu_op_D  in  1 each  decode controls
i_rs1_E, i_rs2_E, i_rd_E  in  REG_AW each  execute registers
i_rf_wr_en_E, i_load_E  in  1 each  execute write enable; execute op is a load
i_rd_M  in  REG_AW  memory-stage destination
i_rf_wr_en_M, i_load_M  in  1 each
i_rd_W  in  REG_AW  writeback-stage destination
i_rf_wr_en_W  in  1
i_lu_done  in  1  long unit writes its result to the register file this edge
i_lu_done_rd  in  REG_AW  destination of the completing op
o_stall_F, o_stall_D  out  1 each  hold PC and decode register
o_flush_D  out  1  clear decode register (taken branch)
o_flush_E  out  1  insert bubble in execute
o_fwdA_D, o_fwdB_D  out  1 each  branch comparator operand taken from ALU_output_M
o_fwdA_E, o_fwdB_E  out  2 each  ALU operand source: 00 regfile, 01 result_W, 10 ALU_output_M
o_lu_busy  out  NUM_REGS  scoreboard busy vector
o_lu_full  out  1  LU_DEPTH ops outstanding
o_lu_err  out  1  sticky: completion mismatch, completion while empty, or timeout
o_stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, async): busy vector=0, FIFO empty, age=0, o_lu_err=0, o_stall_count=0. All other outputs are combinational and evaluate with an empty scoreboard.
- match(X, r) = i_rf_wr_en_X & (i_rd_X != 0) & (i_rd_X == r).
- fwdA_E = 10 if match(M, rs1_E); else 01 if match(W, rs1_E); else 00. M has priority over W. B uses rs2_E the same way.
- fwdA_D = match(M, rs1_D) & ~i_load_M. B uses rs2_D the same way.
- lw_stall = i_load_E & match(E, rs1_D or rs2_D).
- br_stall = i_branch_D & (match(E, rs1_D/rs2_D) | (i_load_M & match(M, rs1_D/rs2_D))).
- sb_stall = busy[rs1_D] | busy[rs2_D] | (i_rf_wr_en_D & busy[rd_D]) | (i_lu_op_D & o_lu_full). The rd term blocks WAW.
- stall = OR of the three terms. o_stall_F = o_stall_D = o_flush_E = stall. o_flush_D = i_branch_taken_D & ~stall.
- Issue: on the edge where i_lu_op_D & i_rf_wr_en_D & rd_D!=0 & ~stall, push rd_D to the tag FIFO and set busy[rd_D]. rd_D=0 issues nothing.
- Completion (i_lu_done):
  - FIFO empty: set o_lu_err; no other state change.
  - Otherwise pop head and clear busy[head].
  - If head != i_lu_done_rd, also set o_lu_err.
- Busy and full are registered: a completing register un-stalls D on the cycle after i_lu_done.
- Simultaneous issue and done: push and pop both occur and the count is unchanged. When full, issue stays stalled that cycle (full is registered; conservative).
- Watchdog: age counter runs while the FIFO is non-empty and resets to 0 on any pop. When age reaches MAX_LAT without i_lu_done: pop head, clear its busy bit, set o_lu_err. If done arrives on that same edge, it is a normal completion (no error).
- o_lu_err is cleared only by reset. o_stall_count increments each cycle stall=1 and saturates at all-ones.

Decomposition:
- riscv_pkg: REG_AW, forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module lu_tag_fifo (LU_DEPTH x REG_AW, push/pop/full/empty/head, simultaneous push+pop legal).

Test Plan:
- add x5 in M, sub rs1_E=5 in E; W also writes x5 -> fwdA_E=10; M write disabled -> fwdA_E=01; rd=0 -> 00.
- lw x6 in E, D reads x6 -> stall_F/D=1, flush_E=1 for exactly 1 cycle; stall_count=1.
- beq x7 in D, x7 produced in E -> 1 stall cycle, then fwdA_D=1 next cycle; with taken=1 and no stall -> flush_D=1.
- Issue mul x8; D reads x8 -> stalls until the cycle after i_lu_done rd=8, then busy[8]=0 and err=0.
- Issue 4 long ops to x1..x4 -> o_lu_full=1, 5th lu op stalls; then i_lu_done rd=1 -> full drops next cycle.
- Issue to x9, no done for MAX_LAT=34 cycles -> busy[9] cleared, o_lu_err=1 sticky; done while empty -> err stays 1; rst low mid-operation -> all state cleared immediately.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the hazard scoreboard and its datapath hookup.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_AW = 5;

  // ALU operand source selected by the execute-stage forwarding muxes
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Individual reasons the front of the pipe is held
  typedef struct packed {
    logic lw;
    logic br;
    logic sb;
  } stall_cause_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Stage-register fields in, hazard controls out. The datapath is master.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = hazard_scoreboard_pkg::REG_AW,
  parameter int unsigned CNT_W    = 32
);

  logic [REG_AW-1:0]   i_rs1_D, i_rs2_D, i_rd_D;
  logic                i_rf_wr_en_D, i_branch_D, i_branch_taken_D, i_lu_op_D;
  logic [REG_AW-1:0]   i_rs1_E, i_rs2_E, i_rd_E;
  logic                i_rf_wr_en_E, i_load_E;
  logic [REG_AW-1:0]   i_rd_M;
  logic                i_rf_wr_en_M, i_load_M;
  logic [REG_AW-1:0]   i_rd_W;
  logic                i_rf_wr_en_W;
  logic                i_lu_done;
  logic [REG_AW-1:0]   i_lu_done_rd;

  logic                o_stall_F, o_stall_D, o_flush_D, o_flush_E;
  logic                o_fwdA_D, o_fwdB_D;
  logic [1:0]          o_fwdA_E, o_fwdB_E;
  logic [NUM_REGS-1:0] o_lu_busy;
  logic                o_lu_full, o_lu_err;
  logic [CNT_W-1:0]    o_stall_count;

  modport master (
    output i_rs1_D, i_rs2_D, i_rd_D, i_rf_wr_en_D, i_branch_D, i_branch_taken_D, i_lu_op_D,
    output i_rs1_E, i_rs2_E, i_rd_E, i_rf_wr_en_E, i_load_E,
    output i_rd_M, i_rf_wr_en_M, i_load_M, i_rd_W, i_rf_wr_en_W,
    output i_lu_done, i_lu_done_rd,
    input  o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_fwdA_D, o_fwdB_D,
    input  o_fwdA_E, o_fwdB_E, o_lu_busy, o_lu_full, o_lu_err, o_stall_count
  );

  modport slave (
    input  i_rs1_D, i_rs2_D, i_rd_D, i_rf_wr_en_D, i_branch_D, i_branch_taken_D, i_lu_op_D,
    input  i_rs1_E, i_rs2_E, i_rd_E, i_rf_wr_en_E, i_load_E,
    input  i_rd_M, i_rf_wr_en_M, i_load_M, i_rd_W, i_rf_wr_en_W,
    input  i_lu_done, i_lu_done_rd,
    output o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_fwdA_D, o_fwdB_D,
    output o_fwdA_E, o_fwdB_E, o_lu_busy, o_lu_full, o_lu_err, o_stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_lu_tag_fifo.sv
// In-order destination-tag FIFO for outstanding long-unit ops.
module hazard_scoreboard_lu_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  // Push into a full FIFO is only legal when the head leaves on the same edge
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Tag storage, no reset needed: guarded by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding, load-use/branch stalls, long-unit scoreboard.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = hazard_scoreboard_pkg::REG_AW,
  parameter int unsigned LU_DEPTH = 4,
  parameter int unsigned MAX_LAT  = 34,
  parameter int unsigned CNT_W    = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave hz
);

  import hazard_scoreboard_pkg::*;

  localparam int unsigned AGE_W = $clog2(MAX_LAT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AGE_W-1:0]    age_q;
  logic                err_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic                fifo_full, fifo_empty;
  logic [REG_AW-1:0]   fifo_head;

  stall_cause_t        cause;
  fwd_sel_e            fwd_a_e, fwd_b_e;
  logic                stall, issue, done_pop, timeout, pop, err_set;

  function automatic logic match(input logic wr_en, input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] r);
    return wr_en && (rd != '0) && (rd == r);
  endfunction

  // Execute-stage operand forwarding, memory stage wins over writeback
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs1_E))      fwd_a_e = FWD_M;
    else if (match(hz.i_rf_wr_en_W, hz.i_rd_W, hz.i_rs1_E)) fwd_a_e = FWD_W;
    if (match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs2_E))      fwd_b_e = FWD_M;
    else if (match(hz.i_rf_wr_en_W, hz.i_rd_W, hz.i_rs2_E)) fwd_b_e = FWD_W;
  end

  // Stall sources; the rd term in the scoreboard check blocks WAW on a busy register
  always_comb begin
    cause    = '0;
    cause.lw = hz.i_load_E &
               (match(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs1_D) |
                match(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs2_D));
    cause.br = hz.i_branch_D &
               (match(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs1_D) |
                match(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs2_D) |
                (hz.i_load_M & (match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs1_D) |
                                match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs2_D))));
    cause.sb = busy_q[hz.i_rs1_D] | busy_q[hz.i_rs2_D] |
               (hz.i_rf_wr_en_D & busy_q[hz.i_rd_D]) |
               (hz.i_lu_op_D & fifo_full);
  end

  assign stall = |cause;

  // Scoreboard events for this edge; a completion on the timeout edge is not an error
  always_comb begin
    issue    = hz.i_lu_op_D & hz.i_rf_wr_en_D & (hz.i_rd_D != '0) & ~stall;
    done_pop = hz.i_lu_done & ~fifo_empty;
    timeout  = ~fifo_empty & ~hz.i_lu_done & (age_q == AGE_W'(MAX_LAT));
    pop      = done_pop | timeout;
    err_set  = (hz.i_lu_done & fifo_empty) |
               (done_pop & (fifo_head != hz.i_lu_done_rd)) |
               timeout;
    busy_d   = busy_q;
    if (pop)   busy_d[fifo_head] = 1'b0;
    if (issue) busy_d[hz.i_rd_D] = 1'b1;
  end

  hazard_scoreboard_lu_tag_fifo #(
    .DEPTH (LU_DEPTH),
    .W     (REG_AW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (issue),
    .push_data (hz.i_rd_D),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Busy vector, head age, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      age_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (pop || fifo_empty) age_q <= '0;
      else                   age_q <= age_q + AGE_W'(1);
      if (err_set) err_q <= 1'b1;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.o_stall_F     = stall;
  assign hz.o_stall_D     = stall;
  assign hz.o_flush_E     = stall;
  assign hz.o_flush_D     = hz.i_branch_taken_D & ~stall;
  assign hz.o_fwdA_D      = match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs1_D) & ~hz.i_load_M;
  assign hz.o_fwdB_D      = match(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs2_D) & ~hz.i_load_M;
  assign hz.o_fwdA_E      = fwd_a_e;
  assign hz.o_fwdB_E      = fwd_b_e;
  assign hz.o_lu_busy     = busy_q;
  assign hz.o_lu_full     = fifo_full;
  assign hz.o_lu_err      = err_q;
  assign hz.o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard against a queue-based model.
module tb_hazard_scoreboard;

  localparam int unsigned NR      = 32;
  localparam int unsigned RA      = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT     = 34;
  localparam int unsigned CW      = 32;
  localparam longint      CNT_MAX = (64'(1) << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_scoreboard_if #(.NUM_REGS(NR), .REG_AW(RA), .CNT_W(CW)) hz ();

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .REG_AW   (RA),
    .LU_DEPTH (DEPTH),
    .MAX_LAT  (LAT),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the outstanding ops are just an ordered list of destination registers
  int     q[$];
  int     head_age;
  bit     m_err;
  longint m_scnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m(input logic we, input logic [RA-1:0] rd, input logic [RA-1:0] r);
    return we && (rd != 0) && (rd == r);
  endfunction

  function automatic bit busy_m(input logic [RA-1:0] r);
    foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RA-1:0] rs);
    if (m(hz.i_rf_wr_en_M, hz.i_rd_M, rs)) return 2'b10;
    if (m(hz.i_rf_wr_en_W, hz.i_rd_W, rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, sb, e1, e2;
    e1 = m(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs1_D);
    e2 = m(hz.i_rf_wr_en_E, hz.i_rd_E, hz.i_rs2_D);
    lw = hz.i_load_E && (e1 || e2);
    br = hz.i_branch_D && (e1 || e2 || (hz.i_load_M &&
         (m(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs1_D) || m(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs2_D))));
    sb = busy_m(hz.i_rs1_D) || busy_m(hz.i_rs2_D) || (hz.i_rf_wr_en_D && busy_m(hz.i_rd_D)) ||
         (hz.i_lu_op_D && (q.size() == DEPTH));
    return lw || br || sb;
  endfunction

  task automatic check_all();
    logic [NR-1:0] bv;
    bit st;
    bv = '0;
    foreach (q[i]) bv[q[i]] = 1'b1;
    st = exp_stall();
    chk("stall_F", 64'(hz.o_stall_F), 64'(st));
    chk("stall_D", 64'(hz.o_stall_D), 64'(st));
    chk("flush_E", 64'(hz.o_flush_E), 64'(st));
    chk("flush_D", 64'(hz.o_flush_D), 64'(hz.i_branch_taken_D && !st));
    chk("fwdA_D", 64'(hz.o_fwdA_D), 64'(m(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs1_D) && !hz.i_load_M));
    chk("fwdB_D", 64'(hz.o_fwdB_D), 64'(m(hz.i_rf_wr_en_M, hz.i_rd_M, hz.i_rs2_D) && !hz.i_load_M));
    chk("fwdA_E", 64'(hz.o_fwdA_E), 64'(fwd_e(hz.i_rs1_E)));
    chk("fwdB_E", 64'(hz.o_fwdB_E), 64'(fwd_e(hz.i_rs2_E)));
    chk("lu_busy", 64'(hz.o_lu_busy), 64'(bv));
    chk("lu_full", 64'(hz.o_lu_full), 64'(q.size() == DEPTH));
    chk("lu_err", 64'(hz.o_lu_err), 64'(m_err));
    chk("stall_count", 64'(hz.o_stall_count), 64'(m_scnt));
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_update();
    bit st, popped, was_empty, iss;
    st        = exp_stall();
    iss       = hz.i_lu_op_D && hz.i_rf_wr_en_D && (hz.i_rd_D != 0) && !st;
    was_empty = (q.size() == 0);
    popped    = 1'b0;
    if (hz.i_lu_done) begin
      if (was_empty) m_err = 1'b1;
      else begin
        if (q[0] != int'(hz.i_lu_done_rd)) m_err = 1'b1;
        void'(q.pop_front());
        popped = 1'b1;
      end
    end else if (!was_empty && head_age == LAT) begin
      m_err = 1'b1;
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (popped || was_empty) head_age = 0;
    else                     head_age++;
    if (iss) q.push_back(int'(hz.i_rd_D));
    if (st && m_scnt < CNT_MAX) m_scnt++;
  endtask

  task automatic model_reset();
    q.delete();
    head_age = 0;
    m_err    = 1'b0;
    m_scnt   = 0;
  endtask

  task automatic idle();
    hz.i_rs1_D = '0; hz.i_rs2_D = '0; hz.i_rd_D = '0;
    hz.i_rf_wr_en_D = 0; hz.i_branch_D = 0; hz.i_branch_taken_D = 0; hz.i_lu_op_D = 0;
    hz.i_rs1_E = '0; hz.i_rs2_E = '0; hz.i_rd_E = '0; hz.i_rf_wr_en_E = 0; hz.i_load_E = 0;
    hz.i_rd_M = '0; hz.i_rf_wr_en_M = 0; hz.i_load_M = 0;
    hz.i_rd_W = '0; hz.i_rf_wr_en_W = 0;
    hz.i_lu_done = 0; hz.i_lu_done_rd = '0;
  endtask

  // Inputs are applied at the falling edge; sample before the next rising edge
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic issue_lu(input int rd);
    idle();
    hz.i_lu_op_D = 1; hz.i_rf_wr_en_D = 1; hz.i_rd_D = RA'(rd);
    step();
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    chk("rst_busy", 64'(hz.o_lu_busy), 64'(0));
    chk("rst_err", 64'(hz.o_lu_err), 64'(0));
    chk("rst_cnt", 64'(hz.o_stall_count), 64'(0));
    chk("rst_full", 64'(hz.o_lu_full), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Execute forwarding priority
    hz.i_rd_M = 5; hz.i_rf_wr_en_M = 1; hz.i_rd_W = 5; hz.i_rf_wr_en_W = 1; hz.i_rs1_E = 5;
    #1 chk("fwdA_E_M", 64'(hz.o_fwdA_E), 64'(2'b10));
    step();
    hz.i_rf_wr_en_M = 0;
    #1 chk("fwdA_E_W", 64'(hz.o_fwdA_E), 64'(2'b01));
    step();
    hz.i_rf_wr_en_M = 1; hz.i_rd_M = 0; hz.i_rd_W = 0; hz.i_rs1_E = 0;
    #1 chk("fwdA_E_x0", 64'(hz.o_fwdA_E), 64'(2'b00));
    step();

    // Load-use: one stall cycle, then the load has moved to M
    idle();
    hz.i_load_E = 1; hz.i_rd_E = 6; hz.i_rf_wr_en_E = 1; hz.i_rs1_D = 6;
    #1 chk("lw_stall", 64'(hz.o_flush_E), 64'(1));
    step();
    idle();
    hz.i_load_M = 1; hz.i_rd_M = 6; hz.i_rf_wr_en_M = 1; hz.i_rs1_D = 6;
    #1 chk("lw_release", 64'(hz.o_stall_D), 64'(0));
    chk("lw_count", 64'(hz.o_stall_count), 64'(1));
    step();

    // Branch operand produced in E, then forwarded from M
    idle();
    hz.i_branch_D = 1; hz.i_rs1_D = 7; hz.i_rd_E = 7; hz.i_rf_wr_en_E = 1; hz.i_branch_taken_D = 1;
    #1 chk("br_stall", 64'(hz.o_stall_F), 64'(1));
    chk("br_noflush", 64'(hz.o_flush_D), 64'(0));
    step();
    idle();
    hz.i_branch_D = 1; hz.i_rs1_D = 7; hz.i_rd_M = 7; hz.i_rf_wr_en_M = 1; hz.i_branch_taken_D = 1;
    #1 chk("br_fwdA_D", 64'(hz.o_fwdA_D), 64'(1));
    chk("br_flush_D", 64'(hz.o_flush_D), 64'(1));
    step();

    // Long op to x8, dependent read held until the cycle after completion
    issue_lu(8);
    idle(); hz.i_rs1_D = 8;
    for (int i = 0; i < 5; i++) step();
    hz.i_lu_done = 1; hz.i_lu_done_rd = 8;
    #1 chk("mul_held", 64'(hz.o_stall_D), 64'(1));
    step();
    idle(); hz.i_rs1_D = 8;
    #1 chk("mul_free", 64'(hz.o_stall_D), 64'(0));
    chk("mul_busy8", 64'(hz.o_lu_busy[8]), 64'(0));
    chk("mul_err", 64'(hz.o_lu_err), 64'(0));
    step();

    // Fill to capacity, fifth op stalls until a slot frees
    for (int r = 1; r <= 4; r++) issue_lu(r);
    idle(); hz.i_lu_op_D = 1; hz.i_rf_wr_en_D = 1; hz.i_rd_D = 10;
    #1 chk("full_flag", 64'(hz.o_lu_full), 64'(1));
    chk("full_stall", 64'(hz.o_stall_D), 64'(1));
    step();
    hz.i_lu_done = 1; hz.i_lu_done_rd = 1;
    step();
    hz.i_lu_done = 0;
    #1 chk("full_drop", 64'(hz.o_lu_full), 64'(0));
    step();
    idle();
    for (int r = 2; r <= 4; r++) begin
      hz.i_lu_done = 1; hz.i_lu_done_rd = RA'(r); step();
    end
    hz.i_lu_done_rd = 10; step();
    idle();

    // Watchdog on x9, then completion while empty
    issue_lu(9);
    idle();
    for (int i = 0; i < LAT + 2; i++) step();
    #1 chk("wd_busy9", 64'(hz.o_lu_busy[9]), 64'(0));
    chk("wd_err", 64'(hz.o_lu_err), 64'(1));
    hz.i_lu_done = 1; hz.i_lu_done_rd = 3;
    step();
    idle();
    #1 chk("wd_err_sticky", 64'(hz.o_lu_err), 64'(1));
    step();

    // Asynchronous reset with an op outstanding
    issue_lu(12);
    idle(); hz.i_rs1_D = 12;
    step();
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", 64'(hz.o_lu_busy), 64'(0));
    chk("mid_rst_err", 64'(hz.o_lu_err), 64'(0));
    chk("mid_rst_cnt", 64'(hz.o_stall_count), 64'(0));
    chk("mid_rst_stall", 64'(hz.o_stall_D), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomized traffic over a small register window
    for (int n = 0; n < 600; n++) begin
      hz.i_rs1_D = RA'($urandom_range(0, 7)); hz.i_rs2_D = RA'($urandom_range(0, 7));
      hz.i_rd_D = RA'($urandom_range(0, 7));
      hz.i_rf_wr_en_D = 1'($urandom_range(0, 1)); hz.i_branch_D = 1'($urandom_range(0, 3) == 0);
      hz.i_branch_taken_D = 1'($urandom_range(0, 1)); hz.i_lu_op_D = 1'($urandom_range(0, 2) == 0);
      hz.i_rs1_E = RA'($urandom_range(0, 7)); hz.i_rs2_E = RA'($urandom_range(0, 7));
      hz.i_rd_E = RA'($urandom_range(0, 7));
      hz.i_rf_wr_en_E = 1'($urandom_range(0, 1)); hz.i_load_E = 1'($urandom_range(0, 3) == 0);
      hz.i_rd_M = RA'($urandom_range(0, 7));
      hz.i_rf_wr_en_M = 1'($urandom_range(0, 1)); hz.i_load_M = 1'($urandom_range(0, 3) == 0);
      hz.i_rd_W = RA'($urandom_range(0, 7)); hz.i_rf_wr_en_W = 1'($urandom_range(0, 1));
      hz.i_lu_done = 1'($urandom_range(0, 4) == 0);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) hz.i_lu_done_rd = RA'(q[0]);
      else hz.i_lu_done_rd = RA'($urandom_range(0, 7));
      step();
    end

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
